// File: rtl/synapse_pkg.sv
// Shared widths and saturating arithmetic for the spike-to-current synapse.
package synapse_pkg;

  localparam int CUR_W  = 8;
  localparam int RATE_W = 8;

  typedef logic [CUR_W-1:0]  cur_t;
  typedef logic [RATE_W-1:0] rate_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/spike_edge_filter.sv
// Rising-edge detect on a multi-bit spike bus plus refractory hold-off; combinational accept/dropped.
// Outputs valid in the sampling cycle; no backpressure.
module spike_edge_filter #(
  parameter int REFRACTORY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spike_in,
  output logic       accept,
  output logic       dropped
);

  logic       prev_q, prev_d;
  logic [7:0] refr_cnt_q, refr_cnt_d;
  logic       asserted;
  logic       edge_hit;

  always_comb begin
    asserted   = |spike_in;
    edge_hit   = asserted & ~prev_q;
    accept     = edge_hit & (refr_cnt_q == 8'd0);
    dropped    = edge_hit & (refr_cnt_q != 8'd0);
    prev_d     = asserted;
    refr_cnt_d = refr_cnt_q;
    if (accept) begin
      refr_cnt_d = 8'(REFRACTORY);
    end else if (refr_cnt_q != 8'd0) begin
      refr_cnt_d = refr_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 1'b0;
      refr_cnt_q <= 8'd0;
    end else begin
      prev_q     <= prev_d;
      refr_cnt_q <= refr_cnt_d;
    end
  end

endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current synapse with exponential decay and windowed event-rate monitor.
// Edge in cycle N updates outputs in N+1; no backpressure, input sampled every cycle.
module spike_synapse
  import synapse_pkg::*;
#(
  parameter logic [7:0] WEIGHT       = 8'd40,
  parameter int         TAU_SHIFT    = 3,
  parameter int         DECAY_PERIOD = 4,
  parameter int         REFRACTORY   = 4,
  parameter int         WINDOW       = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spike_in,
  output logic [7:0] stim_current,
  output logic       event_pulse,   // "event" is a reserved word
  output logic       dropped,
  output logic [7:0] rate
);

  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int WW = $clog2(WINDOW);

  logic accept, drop_hit;

  spike_edge_filter #(.REFRACTORY(REFRACTORY)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .spike_in (spike_in),
    .accept   (accept),
    .dropped  (drop_hit)
  );

  logic [DW-1:0] decay_cnt_q, decay_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  cur_t          cur_q, cur_d;
  rate_t         evt_cnt_q, evt_cnt_d;
  rate_t         rate_q, rate_d;
  logic          event_q, event_d;
  logic          dropped_q, dropped_d;

  logic  tick;
  cur_t  step;
  cur_t  decayed;
  rate_t evt_inc;

  always_comb begin
    tick        = (decay_cnt_q == DW'(DECAY_PERIOD - 1));
    decay_cnt_d = tick ? '0 : decay_cnt_q + 1'b1;

    // Shift alone stalls below 2^TAU_SHIFT; force a unit step so the current reaches 0.
    step = cur_q >> TAU_SHIFT;
    if (step == '0 && cur_q != '0) step = 8'd1;
    decayed = tick ? cur_q - step : cur_q;
    cur_d   = accept ? sat_add8(decayed, WEIGHT) : decayed;

    evt_inc = sat_add8(evt_cnt_q, {7'd0, accept});
    rate_d  = rate_q;
    if (win_cnt_q == WW'(WINDOW - 1)) begin
      rate_d    = evt_inc;
      evt_cnt_d = '0;
      win_cnt_d = '0;
    end else begin
      evt_cnt_d = evt_inc;
      win_cnt_d = win_cnt_q + 1'b1;
    end

    event_d   = accept;
    dropped_d = drop_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decay_cnt_q <= '0;
      win_cnt_q   <= '0;
      cur_q       <= '0;
      evt_cnt_q   <= '0;
      rate_q      <= '0;
      event_q     <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      decay_cnt_q <= decay_cnt_d;
      win_cnt_q   <= win_cnt_d;
      cur_q       <= cur_d;
      evt_cnt_q   <= evt_cnt_d;
      rate_q      <= rate_d;
      event_q     <= event_d;
      dropped_q   <= dropped_d;
    end
  end

  assign stim_current = cur_q;
  assign event_pulse  = event_q;
  assign dropped      = dropped_q;
  assign rate         = rate_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse: vector table plus hand-written multi-cycle sequences.
module tb_spike_synapse;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spike_in;
  logic [7:0] stim_current, rate, stim_sat, rate_sat;
  logic       event_pulse, dropped, evt_sat, drop_sat;

  always #5 clk = ~clk;

  spike_synapse dut (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (spike_in),
    .stim_current (stim_current),
    .event_pulse  (event_pulse),
    .dropped      (dropped),
    .rate         (rate)
  );

  // Heavy weight so clamping at 255 is reachable with default refractory/decay.
  spike_synapse #(.WEIGHT(8'd200)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (spike_in),
    .stim_current (stim_sat),
    .event_pulse  (evt_sat),
    .dropped      (drop_sat),
    .rate         (rate_sat)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] spike;
    logic [7:0] stim;
    logic       evt;
    logic       drop;
    logic [7:0] rate;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] s);
    rst      = r;
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
  endtask

  vec_t vecs[12];
  int   dec[24];
  int   sat_exp[7];

  initial begin
    int evts;
    int k;
    rst      = 1'b1;
    spike_in = 8'hFF;

    // Reset held with spike high, release with level held, then a fresh edge after refractory.
    vecs[0]  = '{1'b1, 8'hFF, 8'd0,  1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'hFF, 8'd0,  1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 8'hFF, 8'd40, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 8'hFF, 8'd40, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 8'hFF, 8'd40, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 8'hFF, 8'd35, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 8'd35, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 8'h00, 8'd35, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 8'h00, 8'd35, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 8'h00, 8'd31, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 8'h5A, 8'd71, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 8'h5A, 8'd71, 1'b0, 1'b0, 8'd0};

    dec = '{40, 35, 31, 28, 25, 22, 20, 18, 16, 14, 13, 12,
            11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    sat_exp = '{40, 75, 98, 126, 138, 161, 164};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].spike);
      chk($sformatf("vec%0d stim", i),    stim_current, vecs[i].stim);
      chk($sformatf("vec%0d event", i),   event_pulse,  vecs[i].evt);
      chk($sformatf("vec%0d dropped", i), dropped,      vecs[i].drop);
      chk($sformatf("vec%0d rate", i),    rate,         vecs[i].rate);
    end

    // Decay from 40 down to 0, value moving only on every 4th edge.
    do_reset();
    step(1'b0, 8'h01);
    chk("decay first", stim_current, 40);
    for (int e = 2; e <= 100; e++) begin
      step(1'b0, 8'h00);
      k = e / 4;
      chk($sformatf("decay e%0d", e), stim_current, (k < 24) ? dec[k] : 0);
      chk($sformatf("decay evt e%0d", e), event_pulse, 0);
    end

    // Seven spikes, six edges apart; heavy-weight instance clamps at 255.
    do_reset();
    evts = 0;
    k    = 0;
    for (int e = 1; e <= 40; e++) begin
      step(1'b0, (e % 6 == 1) ? 8'h01 : 8'h00);
      if (event_pulse) evts++;
      if (e % 6 == 1) begin
        chk($sformatf("sat stim e%0d", e), stim_current, sat_exp[k]);
        k++;
      end
      if (e == 1)  chk("sat heavy e1",  stim_sat, 200);
      if (e == 7)  chk("sat heavy e7",  stim_sat, 255);
      if (e == 8)  chk("sat heavy e8",  stim_sat, 224);
      if (e == 13) chk("sat heavy e13", stim_sat, 255);
    end
    chk("sat event count", evts, 7);

    // Accept coinciding with decay tick: decay first, then add.
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step(1'b0, (e == 1 || e == 8 || e == 16) ? 8'h01 : 8'h00);
      if (e == 8)  chk("simul e8",  stim_current, 71);
      if (e == 16) chk("simul e16", stim_current, 96);
    end

    // Refractory: edges at N, N+2 (dropped), N+5 (accepted).
    do_reset();
    step(1'b0, 8'h01);
    chk("refr e1 evt", event_pulse, 1);
    step(1'b0, 8'h00);
    step(1'b0, 8'h01);
    chk("refr e3 drop", dropped, 1);
    chk("refr e3 evt", event_pulse, 0);
    chk("refr e3 stim", stim_current, 40);
    step(1'b0, 8'h00);
    chk("refr e4 stim", stim_current, 35);
    step(1'b0, 8'h00);
    step(1'b0, 8'h01);
    chk("refr e6 evt", event_pulse, 1);
    chk("refr e6 drop", dropped, 0);
    chk("refr e6 stim", stim_current, 75);

    // Rate: 10 events in window 1 (last on the closing edge), hold, reset mid-window.
    do_reset();
    evts = 0;
    for (int e = 1; e <= 256; e++) begin
      step(1'b0, (e >= 211 && (e - 211) % 5 == 0) ? 8'h01 : 8'h00);
      if (event_pulse) evts++;
      if (e == 255) chk("rate before close", rate, 0);
      if (e == 256) chk("rate at close", rate, 10);
    end
    chk("rate window1 events", evts, 10);
    for (int e = 257; e <= 400; e++) begin
      step(1'b0, 8'h00);
      if (e == 300 || e == 400) chk($sformatf("rate hold e%0d", e), rate, 10);
    end
    step(1'b1, 8'h00);
    chk("rate in reset", rate, 0);
    step(1'b1, 8'h00);
    for (int e = 1; e <= 256; e++) begin
      step(1'b0, (e == 10 || e == 20 || e == 30) ? 8'h01 : 8'h00);
      if (e == 255) chk("rate2 before close", rate, 0);
      if (e == 256) chk("rate2 at close", rate, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
